// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding one transmitter through a single holding register.
// Optional idle heartbeat word is built when TX_ARB_HEARTBEAT_EN is defined.
module tx_arbiter #(
    parameter int NREQ      = 3,
    parameter int LENGTH    = 128,
    parameter int TAG_W     = 2,
    parameter int PAYLOAD   = LENGTH - TAG_W,
    parameter int HB_PERIOD = 65536
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*PAYLOAD-1:0]   req_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LENGTH-1:0]         out_data_o,
    output logic [15:0]               hb_seq_o
);
    // state    | meaning
    // ST_EMPTY | holding register empty, out_valid_o low
    // ST_FULL  | holding register holds a word for the transmitter
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > (2**TAG_W) - 1) begin : g_bad_nreq
        $error("tx_arbiter: NREQ out of range for TAG_W");
    end
    if (PAYLOAD < 16 || HB_PERIOD < 2) begin : g_bad_sizes
        $error("tx_arbiter: PAYLOAD must be >= 16 and HB_PERIOD >= 2");
    end

    logic [0:0]        state_q, state_d;
    logic [LENGTH-1:0] data_q, data_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  gnt_idx, ptr_nxt;
    logic              gnt_any, load_en, req_load, handshake, hb_load;
    logic [LENGTH-1:0] hb_word;
    int                idx;

    assign out_valid_o = (state_q == ST_FULL);
    assign out_data_o  = data_q;
    assign load_en     = ~out_valid_o | out_ready_i;
    assign handshake   = out_valid_o & out_ready_i;
    assign req_load    = load_en & gnt_any;
    // Gated by rst_i so no requester sees an accept while reset is held.
    assign req_ready_o = (load_en & ~rst_i) ? grant : '0;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid_i[idx]) begin
                gnt_any      = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = PTR_W'(idx);
            end
        end
    end

    assign ptr_nxt = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (req_load) begin
            state_d = ST_FULL;
            data_d  = {TAG_W'(gnt_idx), req_data_i[int'(gnt_idx)*PAYLOAD +: PAYLOAD]};
            ptr_d   = ptr_nxt;
        end else if (hb_load) begin
            state_d = ST_FULL;
            data_d  = hb_word;
        end else if (handshake) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef TX_ARB_HEARTBEAT_EN
    localparam int CNT_W = $clog2(HB_PERIOD);
    localparam logic [TAG_W-1:0] HB_TAG = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [15:0]      seq_q, seq_d;

    assign hb_load  = pend_q & load_en & ~(|req_valid_i);
    assign hb_word  = {HB_TAG, {(PAYLOAD-16){1'b0}}, seq_q + 16'd1};
    assign hb_seq_o = seq_q;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        pend_d = pend_q;
        seq_d  = seq_q;
        if (handshake || req_load || hb_load) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(HB_PERIOD - 1)) begin
            cnt_d  = '0;
            pend_d = 1'b1;
        end
        // Any load, data or heartbeat, satisfies the pending heartbeat.
        if (req_load || hb_load) pend_d = 1'b0;
        if (hb_load) seq_d = seq_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            seq_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            seq_q  <= seq_d;
        end
    end
`else
    assign hb_load  = 1'b0;
    assign hb_word  = '0;
    assign hb_seq_o = '0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset, single requester, round-robin,
// backpressure, and heartbeat behaviour when TX_ARB_HEARTBEAT_EN is defined.
module tb_tx_arbiter;
    localparam int NREQ      = 3;
    localparam int LENGTH    = 128;
    localparam int TAG_W     = 2;
    localparam int PAYLOAD   = LENGTH - TAG_W;
    localparam int HB_PERIOD = 8;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic [NREQ-1:0]         req_valid_i = '0;
    logic [NREQ-1:0]         req_ready_o;
    logic [NREQ*PAYLOAD-1:0] req_data_i = '0;
    logic                    out_valid_o;
    logic                    out_ready_i = 1'b0;
    logic [LENGTH-1:0]       out_data_o;
    logic [15:0]             hb_seq_o;

    int n_tests = 0;
    int n_fail  = 0;

    tx_arbiter #(
        .NREQ(NREQ), .LENGTH(LENGTH), .TAG_W(TAG_W), .PAYLOAD(PAYLOAD), .HB_PERIOD(HB_PERIOD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .hb_seq_o(hb_seq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LENGTH-1:0] obs, input logic [LENGTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [PAYLOAD-1:0] v);
        req_data_i[i*PAYLOAD +: PAYLOAD] = v;
    endtask

    function automatic logic [LENGTH-1:0] word(input logic [TAG_W-1:0] tag, input logic [PAYLOAD-1:0] p);
        return {tag, p};
    endfunction

    task automatic reset_dut();
        @(negedge clk_i);
        rst_i       = 1'b1;
        req_valid_i = '0;
        out_ready_i = 1'b0;
        req_data_i  = '0;
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset held: outputs cleared and req_ready gated even with requests pending.
        req_valid_i = 3'b111;
        #12;
        chk("rst_valid", LENGTH'(out_valid_o), '0);
        chk("rst_data", out_data_o, '0);
        chk("rst_ready", LENGTH'(req_ready_o), '0);
        chk("rst_hbseq", LENGTH'(hb_seq_o), '0);
        reset_dut();

        // Asynchronous reset while FULL with 0x5.
        tick();
        req_valid_i = 3'b001;
        set_data(0, 'h5);
        #1;
        chk("ld0_ready", LENGTH'(req_ready_o), 3'b001);
        tick();
        req_valid_i = 3'b000;
        chk("ld0_valid", LENGTH'(out_valid_o), 1);
        chk("ld0_data", out_data_o, word(2'd0, 'h5));
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_valid", LENGTH'(out_valid_o), 0);
        chk("async_data", out_data_o, '0);
        #2;
        rst_i = 1'b0;
        req_valid_i = 3'b111;
        #1;
        chk("post_rst_grant", LENGTH'(req_ready_o), 3'b001);
        tick();
        chk("post_rst_data", out_data_o, word(2'd0, 'h5));

        // Single requester 1, out_ready pulsing every 4 cycles.
        reset_dut();
        req_valid_i = 3'b010;
        set_data(1, 'hABC);
        #1;
        chk("single_ready0", LENGTH'(req_ready_o), 3'b010);
        tick();
        chk("single_valid0", LENGTH'(out_valid_o), 1);
        chk("single_data0", out_data_o, word(2'b01, 'hABC));
        set_data(1, 'hABD);
        for (int p = 0; p < 3; p++) begin
            repeat (3) begin
                tick();
                chk("single_hold_ready", LENGTH'(req_ready_o), '0);
                chk("single_hold_data", out_data_o, word(2'b01, PAYLOAD'('hABC + p)));
            end
            out_ready_i = 1'b1;
            #1;
            chk("single_pulse_ready", LENGTH'(req_ready_o), 3'b010);
            tick();
            out_ready_i = 1'b0;
            chk("single_nobubble", LENGTH'(out_valid_o), 1);
            chk("single_data", out_data_o, word(2'b01, PAYLOAD'('hABD + p)));
            set_data(1, PAYLOAD'('hABE + p));
        end

        // Round-robin with all requesters valid and out_ready held high.
        reset_dut();
        set_data(0, 'h100);
        set_data(1, 'h111);
        set_data(2, 'h122);
        req_valid_i = 3'b111;
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", LENGTH'(req_ready_o), LENGTH'(3'b001 << (k % 3)));
            tick();
            chk("rr_data", out_data_o, word(TAG_W'(k % 3), PAYLOAD'('h100 + 'h11 * (k % 3))));
        end

        // Backpressure: 20 cycles stalled, then drain and same-cycle reload.
        out_ready_i = 1'b0;
        repeat (20) begin
            tick();
            chk("bp_ready", LENGTH'(req_ready_o), '0);
            chk("bp_data", out_data_o, word(2'd2, 'h122));
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", LENGTH'(req_ready_o), 3'b001);
        tick();
        out_ready_i = 1'b0;
        chk("bp_reload_valid", LENGTH'(out_valid_o), 1);
        chk("bp_reload_data", out_data_o, word(2'd0, 'h100));

        // Drain with no requests: valid drops, data holds.
        req_valid_i = '0;
        out_ready_i = 1'b1;
        #1;
        chk("drain_ready", LENGTH'(req_ready_o), '0);
        tick();
        chk("drain_valid", LENGTH'(out_valid_o), 0);
        chk("drain_data", out_data_o, word(2'd0, 'h100));

`ifdef TX_ARB_HEARTBEAT_EN
        // Idle heartbeats at edges 9 and 19 after reset release.
        reset_dut();
        out_ready_i = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            chk("hb_valid", LENGTH'(out_valid_o), LENGTH'(e == 9 || e == 19));
            if (e == 9) begin
                chk("hb1_data", out_data_o, word(2'b11, 'd1));
                chk("hb1_seq", LENGTH'(hb_seq_o), 1);
            end
            if (e == 19) begin
                chk("hb2_data", out_data_o, word(2'b11, 'd2));
                chk("hb2_seq", LENGTH'(hb_seq_o), 2);
            end
        end

        // Requester arrives while heartbeat is pending: data wins, pending cleared.
        reset_dut();
        out_ready_i = 1'b1;
        repeat (8) tick();
        chk("hbd_idle", LENGTH'(out_valid_o), 0);
        req_valid_i = 3'b010;
        set_data(1, 'h777);
        #1;
        chk("hbd_ready", LENGTH'(req_ready_o), 3'b010);
        tick();
        req_valid_i = '0;
        chk("hbd_data", out_data_o, word(2'b01, 'h777));
        chk("hbd_seq", LENGTH'(hb_seq_o), 0);
        tick();
        chk("hbd_no_hb", LENGTH'(out_valid_o), 0);
        chk("hbd_seq2", LENGTH'(hb_seq_o), 0);
`else
        // Without heartbeat support the link stays silent when idle.
        reset_dut();
        out_ready_i = 1'b1;
        repeat (20) begin
            tick();
            chk("nohb_valid", LENGTH'(out_valid_o), 0);
        end
        chk("nohb_seq", LENGTH'(hb_seq_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares one frontend serial data transmitter between `NREQ` requesters, such as the event packer, command responder and status reporter. It owns a single output holding register and presents it to the transmitter's valid/ready input. Each word is tagged with its source index in the top bits. An optional heartbeat word keeps the link visibly alive during long idle periods.

## Interface
Parameters:
- `NREQ`, 3: number of requesters; must satisfy 1 ≤ `NREQ` ≤ 2^`TAG_W` − 1.
- `LENGTH`, 128: output word width; matches the transmitter `LENGTH`.
- `TAG_W`, 2: source-tag width. The all-ones tag is reserved for heartbeat.
- `PAYLOAD`, `LENGTH` − `TAG_W`: requester data width (derived; must be ≥ 16).
- `HB_PERIOD`, 65536: idle cycles before a heartbeat (heartbeat builds only; ≥ 2).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `NREQ`: per-requester valid.
- `req_ready`, out, `NREQ`: per-requester accept; at most one bit set per cycle.
- `req_data`, in, `NREQ`*`PAYLOAD`: flattened payloads; requester i occupies bits [i*`PAYLOAD` +: `PAYLOAD`].
- `out_valid`, out, 1: holding register full; drives transmitter `valid`.
- `out_ready`, in, 1: transmitter `ready`; may be a one-cycle pulse.
- `out_data`, out, `LENGTH`: {tag, payload}; drives transmitter `data_in`.
- `hb_seq`, out, 16: heartbeat count (zero in non-heartbeat builds).

## Operation
- Holding register has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en` = ~`out_valid` | `out_ready`. This allows a back-to-back reload in the same cycle as the drain.
- Grant is combinational: search `req_valid` starting at pointer `ptr`, ascending with wrap modulo `NREQ`. The first set bit is granted.
- `req_ready[i]` = `load_en` & grant[i]. A transfer occurs when `req_valid[i]` & `req_ready[i]`.
- On a transfer from i:
  - `out_data` ← {i[`TAG_W`-1:0], `req_data[i]`} and `out_valid` ← 1.
  - `ptr` ← (i+1) mod `NREQ`.
- If `out_valid` & `out_ready` and nothing is loaded: `out_valid` ← 0. `out_data` holds its last value.
- `ptr` is unchanged when nothing is granted.
- Requester valid is sticky by contract: a requester holds `req_valid` and data until it is accepted. The arbiter does not check this.
- With `NREQ`=1, the block degenerates to a single register slice.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `req_ready`=0 while `rst` is high.
  - `ptr`=0, `hb_seq`=0, heartbeat counter=0, heartbeat pending=0.
- Latency: accepted at edge k → `out_valid`/`out_data` valid after edge k, so visible in cycle k+1.
- Throughput: one word per `out_ready` pulse, with no bubble when a requester is valid at the pulse.
- Fairness: a continuously valid requester waits at most `NREQ`−1 grants.
- Reset asserted mid-operation clears everything asynchronously. A held word is dropped and not retransmitted.
- `out_data` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `TX_ARB_HEARTBEAT_EN` defined:
  - Idle counter increments every cycle. It clears on any `out_valid` & `out_ready` handshake and on any load.
  - When the counter reaches `HB_PERIOD`−1, heartbeat pending ← 1 and the counter clears.
  - Pending and `load_en` and no `req_valid` → load {all-ones tag, zeros, `hb_seq`+1 in bits [15:0]}. Then `hb_seq` increments (wraps at 16 bits) and pending clears.
  - Requesters always win over a pending heartbeat. Any requester load also clears pending.
  - Heartbeat loads do not move `ptr`.
- Not defined: no counter or pending logic; `hb_seq` is tied to 0; the all-ones tag never appears.

## Test plan
- Reset: assert `rst` asynchronously mid-FULL, with `out_data`=0x5 and `out_valid`=1 → `out_valid`=0 and `out_data`=0 immediately, without waiting for a clock edge; after release, first grant goes to requester 0.
- Single requester: `req_valid`=3'b010, payload 0xABC, `out_ready` pulsing every 4 cycles → one transfer per pulse, `out_data` top bits=2'b01, low bits=0xABC, no bubbles.
- Round-robin: all three requesters valid continuously, `out_ready`=1 → grant order 0,1,2,0,1,2; `req_ready` always one-hot.
- Backpressure: `out_ready`=0 for 20 cycles while FULL → `out_data` stable, `req_ready`=0; at the first `out_ready` pulse, drain and same-cycle reload of the next requester.
- Heartbeat (`TX_ARB_HEARTBEAT_EN`, `HB_PERIOD`=8): no requests, `out_ready`=1 → heartbeat word tag 2'b11 with bits[15:0]=1, then 2, every 8 idle cycles.
- Heartbeat vs data (`HB_PERIOD`=8): requester 1 goes valid in the same cycle pending sets → requester 1 word sent, pending cleared, and `hb_seq` unchanged.
